// File: rtl/jt12_eg_pkg.sv
// Shared constants, state codes and helpers for the envelope generator.
package jt12_eg_pkg;

  localparam int         EG_CNT_W = 15;
  localparam logic [9:0] ATT_MAX  = 10'h3FF;

  typedef enum logic [1:0] {
    ATTACK  = 2'd0,
    DECAY1  = 2'd1,
    DECAY2  = 2'd2,
    RELEASE = 2'd3
  } eg_state_t;

  // Sustain level compared against the top five attenuation bits; sl=15 maps to the floor.
  function automatic logic [4:0] sl_to_level(input logic [3:0] sl);
    return (sl == 4'hF) ? 5'd31 : {sl, 1'b0};
  endfunction

endpackage

// File: rtl/jt12_eg_env_if.sv
// Link between the envelope core and the rate step calculator.
interface jt12_eg_env_if;
  import jt12_eg_pkg::*;

  // No handshake: the env drives base_rate/attack/eg_cnt/cnt_in from registers only, and the
  // step calculator answers combinationally (step/rate/sum_up/cnt_lsb) within the same clk.
  logic [4:0]          base_rate;
  logic                attack;
  logic [EG_CNT_W-1:0] eg_cnt;
  logic                cnt_in;
  logic                step;
  logic [5:0]          rate;
  logic                sum_up;
  logic                cnt_lsb;

  modport master (
    output base_rate, attack, eg_cnt, cnt_in,
    input  step, rate, sum_up, cnt_lsb
  );

  modport slave (
    input  base_rate, attack, eg_cnt, cnt_in,
    output step, rate, sum_up, cnt_lsb
  );

endinterface

// File: rtl/jt12_eg_cnt.sv
// Envelope prescaler and global 15-bit envelope counter.
module jt12_eg_cnt
  import jt12_eg_pkg::*;
#(
  parameter int PRESCALE = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  output logic                tick,
  output logic [EG_CNT_W-1:0] eg_cnt
);

  localparam int                  PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]       PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [EG_CNT_W-1:0] CNT_LAST = '1;
  localparam logic [EG_CNT_W-1:0] CNT_ONE  = EG_CNT_W'(1);

  logic [PW-1:0] presc;

  assign tick = clk_en && (presc == PRE_LAST);

  // Counter skips zero on wrap so zero only ever marks "just out of reset".
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc  <= '0;
      eg_cnt <= '0;
    end else begin
      if (clk_en) presc <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
      if (tick)   eg_cnt <= (eg_cnt == CNT_LAST) ? CNT_ONE : eg_cnt + CNT_ONE;
    end
  end

endmodule

// File: rtl/jt12_eg_env.sv
// Single-operator envelope generator: ADSR state machine and attenuation register.
module jt12_eg_env
  import jt12_eg_pkg::*;
#(
  parameter int PRESCALE = 3,
  parameter int ATT_W    = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             keyon,
  input  logic [4:0]       ar,
  input  logic [4:0]       d1r,
  input  logic [4:0]       d2r,
  input  logic [3:0]       rr,
  input  logic [3:0]       sl,
  jt12_eg_env_if.master    sc,
  output logic [ATT_W-1:0] eg_att,
  output logic [1:0]       eg_state
);

  localparam logic [ATT_W-1:0] ATT_TOP = '1;
  localparam int               MW      = ATT_W + 5;

  eg_state_t           state_q, state_d;
  logic [ATT_W-1:0]    att_d, att_upd;
  logic [EG_CNT_W-1:0] eg_cnt;
  logic                tick, upd, kon_q, cnt_in_q, kon_rise, kon_fall;
  logic [4:0]          inc;
  logic [MW-1:0]       att_mul, att_dec;
  logic [ATT_W:0]      att_sum;

  jt12_eg_cnt #(.PRESCALE(PRESCALE)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (clk_en),
    .tick   (tick),
    .eg_cnt (eg_cnt)
  );

  assign sc.eg_cnt = eg_cnt;
  assign sc.cnt_in = cnt_in_q;
  assign sc.attack = (state_q == ATTACK);
  assign eg_state  = state_q;

  assign upd      = tick && sc.sum_up && sc.step;
  assign kon_rise = keyon && !kon_q;
  assign kon_fall = !keyon && kon_q;

  always_comb begin
    sc.base_rate = ar;
    case (state_q)
      DECAY1:  sc.base_rate = d1r;
      DECAY2:  sc.base_rate = d2r;
      RELEASE: sc.base_rate = {rr, 1'b1};
      default: sc.base_rate = ar;
    endcase
  end

  // High rates take larger steps: 2, 4, 8, 16 for rate[5:2] = 12..15.
  always_comb begin
    inc = 5'd1;
    if (sc.rate[5:2] >= 4'd12) inc = 5'd1 << (sc.rate[5:2] - 4'd11);
  end

  // Attack is exponential towards zero; the others are linear and saturate at silence.
  always_comb begin
    att_mul = MW'(eg_att) * MW'(inc);
    att_dec = (att_mul >> 4) + MW'(1);
    att_sum = {1'b0, eg_att} + (ATT_W + 1)'(inc);
    if (state_q == ATTACK)
      att_upd = (att_dec >= MW'(eg_att)) ? '0 : eg_att - att_dec[ATT_W-1:0];
    else
      att_upd = att_sum[ATT_W] ? ATT_TOP : att_sum[ATT_W-1:0];
  end

  // Key edges take priority and drop any coincident level update.
  always_comb begin
    state_d = state_q;
    att_d   = eg_att;
    if (clk_en) begin
      if (kon_rise) begin
        if (ar == 5'd31) begin
          state_d = DECAY1;
          att_d   = '0;
        end else begin
          state_d = ATTACK;
        end
      end else if (kon_fall) begin
        state_d = RELEASE;
      end else begin
        if (upd) att_d = att_upd;
        case (state_q)
          ATTACK:  if (att_d == '0) state_d = DECAY1;
          DECAY1:  if (att_d[ATT_W-1:ATT_W-5] >= sl_to_level(sl)) state_d = DECAY2;
          default: state_d = state_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= RELEASE;
      eg_att   <= ATT_TOP;
      kon_q    <= 1'b0;
      cnt_in_q <= 1'b0;
    end else begin
      state_q <= state_d;
      eg_att  <= att_d;
      if (clk_en) kon_q    <= keyon;
      if (tick)   cnt_in_q <= sc.cnt_lsb;
    end
  end

endmodule

// File: tb/tb_jt12_eg_env.sv
// Bench for jt12_eg_env: random step-calculator replies, ADSR reference model and scoreboard.
module tb_jt12_eg_env;
  import jt12_eg_pkg::*;

  localparam int W = 34;

  logic       clk = 1'b0;
  logic       rst_n, clk_en, keyon;
  logic [4:0] ar, d1r, d2r;
  logic [3:0] rr, sl;
  logic [9:0] eg_att, w_att;
  logic [1:0] eg_state, w_state;

  jt12_eg_env_if sc ();
  jt12_eg_env_if wsc ();

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  int m_att, m_state, m_cnt, m_presc;
  bit m_kon, m_cnt_in;
  bit force_upd = 1'b0;
  bit wrap_done = 1'b0;

  always #5 clk = ~clk;

  jt12_eg_env dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .keyon(keyon),
    .ar(ar), .d1r(d1r), .d2r(d2r), .rr(rr), .sl(sl),
    .sc(sc.master), .eg_att(eg_att), .eg_state(eg_state)
  );

  // Second instance with no prescaling so the counter wrap is reachable quickly.
  jt12_eg_env #(.PRESCALE(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .clk_en(1'b1), .keyon(1'b0),
    .ar(5'd0), .d1r(5'd0), .d2r(5'd0), .rr(4'd0), .sl(4'd0),
    .sc(wsc.master), .eg_att(w_att), .eg_state(w_state)
  );

  assign wsc.step    = 1'b0;
  assign wsc.rate    = 6'd0;
  assign wsc.sum_up  = 1'b0;
  assign wsc.cnt_lsb = 1'b0;

  function automatic int m_base_rate();
    case (m_state)
      0:       return int'(ar);
      1:       return int'(d1r);
      2:       return int'(d2r);
      default: return int'(rr) * 2 + 1;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, act, exp);
    end
  endtask

  // One clk: choose step-calculator replies, advance the model, queue the expected outputs.
  task automatic cyc(input bit en);
    int br, rq, inc, dec, lvl;
    bit tick, upd, rise, fall;
    clk_en = en;
    br = m_base_rate();
    if (force_upd) begin
      sc.step = 1'b1; sc.sum_up = 1'b1; sc.rate = 6'd63;
    end else begin
      sc.step   = (br != 0) && ($urandom_range(0, 1) == 1);
      sc.sum_up = $urandom_range(0, 1);
      sc.rate   = 6'(br * 2 + int'($urandom_range(0, 1)));
    end
    sc.cnt_lsb = $urandom_range(0, 1);
    if (!rst_n) begin
      m_att = 1023; m_state = 3; m_cnt = 0; m_presc = 0; m_kon = 0; m_cnt_in = 0;
    end else if (en) begin
      tick    = (m_presc == 2);
      m_presc = (m_presc + 1) % 3;
      upd     = tick && sc.step && sc.sum_up;
      rq      = int'(sc.rate) / 4;
      inc     = (rq < 12) ? 1 : (1 << (rq - 11));
      if (tick) begin
        m_cnt    = (m_cnt == 32767) ? 1 : m_cnt + 1;
        m_cnt_in = sc.cnt_lsb;
      end
      rise  = keyon && !m_kon;
      fall  = !keyon && m_kon;
      m_kon = keyon;
      if (rise) begin
        if (ar == 31) begin m_att = 0; m_state = 1; end
        else m_state = 0;
      end else if (fall) begin
        m_state = 3;
      end else begin
        if (upd) begin
          if (m_state == 0) begin
            dec   = (m_att * inc) / 16 + 1;
            m_att = (dec >= m_att) ? 0 : m_att - dec;
          end else begin
            m_att = (m_att + inc > 1023) ? 1023 : m_att + inc;
          end
        end
        lvl = (sl == 15) ? 31 : int'(sl) * 2;
        if (m_state == 0 && m_att == 0) m_state = 1;
        else if (m_state == 1 && m_att / 32 >= lvl) m_state = 2;
      end
    end
    br = m_base_rate();
    exp_q.push_back({2'(m_state), 10'(m_att), 15'(m_cnt), m_cnt_in, 5'(br), (m_state == 0)});
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      logic [W-1:0] e, a;
      e = exp_q.pop_front();
      a = {eg_state, eg_att, sc.eg_cnt, sc.cnt_in, sc.base_rate, sc.attack};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL scoreboard t=%0t got st=%0d att=%h cnt=%h cin=%b br=%0d atk=%b exp st=%0d att=%h cnt=%h cin=%b br=%0d atk=%b",
                 $time, a[33:32], a[31:22], a[21:7], a[6], a[5:1], a[0],
                 e[33:32], e[31:22], e[21:7], e[6], e[5:1], e[0]);
      end
    end
  end

  initial begin : wrap_chk
    wait (rst_n === 1'b1);
    repeat (32767) @(posedge clk);
    #1;
    check("wrap_max", int'(wsc.eg_cnt), 32'h7FFF);
    @(posedge clk);
    #1;
    check("wrap_one", int'(wsc.eg_cnt), 1);
    wrap_done = 1'b1;
  end

  initial begin : main
    int n, pre;
    rst_n = 1'b0; keyon = 1'b0; clk_en = 1'b0;
    ar = 5'd0; d1r = 5'd0; d2r = 5'd0; rr = 4'd0; sl = 4'd2;
    sc.step = 1'b0; sc.rate = 6'd0; sc.sum_up = 1'b0; sc.cnt_lsb = 1'b0;

    for (int i = 0; i < 6; i++) cyc(i % 2);
    check("rst_att", int'(eg_att), int'(ATT_MAX));
    check("rst_state", int'(eg_state), 3);
    check("rst_cnt", int'(sc.eg_cnt), 0);
    rst_n = 1'b1;
    cyc(1); cyc(0); cyc(1); cyc(0); cyc(1);
    check("first_tick_cnt", int'(sc.eg_cnt), 1);

    // Instant attack
    ar = 5'd31; keyon = 1'b1;
    cyc(1);
    check("ar31_att", int'(eg_att), 0);
    check("ar31_state", int'(eg_state), 1);

    // Key off in DECAY1, then release saturates at silence
    keyon = 1'b0; rr = 4'd15;
    cyc(1);
    check("keyoff_state", int'(eg_state), 3);
    n = 0;
    while (m_att != 1023 && n < 3000) begin cyc(1); n++; end
    check("rel_sat_att", int'(eg_att), 1023);
    repeat (60) cyc(1);
    check("rel_hold_att", int'(eg_att), 1023);

    // Attack convergence then decay chain into DECAY2 at 0x080
    ar = 5'd20; d1r = 5'd20; sl = 4'd2; keyon = 1'b1;
    cyc(1);
    check("atk_state", int'(eg_state), 0);
    n = 0;
    while (m_state == 0 && n < 20000) begin cyc(1); n++; end
    check("atk_done_state", int'(eg_state), 1);
    check("atk_done_att", int'(eg_att), 0);
    n = 0;
    while (m_state == 1 && n < 20000) begin cyc(1); n++; end
    check("d2_state", int'(eg_state), 2);
    check("d2_att", int'(eg_att), 10'h080);

    // Zero rate freezes the level
    d2r = 5'd0;
    repeat (30000) cyc(1);
    check("freeze_att", int'(eg_att), 10'h080);
    check("freeze_state", int'(eg_state), 2);

    // Rising edge coinciding with an update: update dropped
    keyon = 1'b0; rr = 4'd3;
    cyc(1);
    n = 0;
    while (m_presc != 2 && n < 6) begin cyc(1); n++; end
    pre = m_att;
    force_upd = 1'b1; ar = 5'd10; keyon = 1'b1;
    cyc(1);
    force_upd = 1'b0;
    check("rise_upd_state", int'(eg_state), 0);
    check("rise_upd_att", int'(eg_att), pre);

    // Falling edge coinciding with an update: update dropped
    n = 0;
    while (m_presc != 2 && n < 6) begin cyc(1); n++; end
    pre = m_att;
    force_upd = 1'b1; keyon = 1'b0;
    cyc(1);
    force_upd = 1'b0;
    check("fall_upd_state", int'(eg_state), 3);
    check("fall_upd_att", int'(eg_att), pre);

    // Random soak
    for (int i = 0; i < 4000; i++) begin
      if (i % 250 == 0) begin
        ar  = $urandom_range(0, 31); d1r = $urandom_range(0, 31);
        d2r = $urandom_range(0, 31); rr  = $urandom_range(0, 15);
        sl  = $urandom_range(0, 15);
      end
      if ($urandom_range(0, 59) == 0) keyon = ~keyon;
      cyc($urandom_range(0, 9) < 7);
    end

    fork
      begin wait (wrap_done); end
      begin repeat (40000) @(posedge clk); end
    join_any
    disable fork;
    check("wrap_finished", int'(wrap_done), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
